// File: rtl/attr_regs_pkg.sv
// Shared constants and types for the attribute controller CPU-side register front end.
package attr_regs_pkg;

    localparam int unsigned PAL_AW = 4;
    localparam int unsigned IDX_W  = 5;

    localparam logic [IDX_W-1:0] ATTR_MODE = 5'h10;
    localparam logic [IDX_W-1:0] ATTR_OVSC = 5'h11;
    localparam logic [IDX_W-1:0] ATTR_PLEN = 5'h12;
    localparam logic [IDX_W-1:0] ATTR_HPAN = 5'h13;
    localparam logic [IDX_W-1:0] ATTR_CSEL = 5'h14;

    typedef enum logic [1:0] {
        SelArx  = 2'd0,
        SelArdr = 2'd1,
        SelSt01 = 2'd2,
        SelNone = 2'd3
    } io_sel_e;

    typedef enum logic {
        StIdle = 1'b0,
        StAck  = 1'b1
    } attr_state_e;

endpackage

// File: rtl/attr_pal_shadow.sv
// Shadow copy of the internal palette: one synchronous write port, one combinational read port.
module attr_pal_shadow
    import attr_regs_pkg::*;
#(
    parameter int unsigned NUM_PAL = 16,
    parameter int unsigned PAL_W   = 6
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              we_i,
    input  logic [PAL_AW-1:0] waddr_i,
    input  logic [PAL_W-1:0]  wdata_i,
    input  logic [PAL_AW-1:0] raddr_i,
    output logic [PAL_W-1:0]  rdata_o
);

    logic [PAL_W-1:0] mem_q [NUM_PAL];

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_PAL; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/attr_regs.sv
// CPU-side register front end of the VGA attribute controller: 3C0 index/data flip-flop,
// 3C1 readback, 3DA status, palette write strobes and configuration outputs.
module attr_regs
    import attr_regs_pkg::*;
#(
    parameter int unsigned NUM_PAL = 16,
    parameter int unsigned PAL_W   = 6
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              io_req_i,
    input  logic              io_we_i,
    input  logic [1:0]        io_sel_i,
    input  logic [7:0]        io_data_i,
    output logic [7:0]        io_data_o,
    output logic              io_ack_o,
    input  logic              hblank_i,
    input  logic              vblank_i,
    output logic              pal_write_o,
    output logic [PAL_AW-1:0] pal_addr_o,
    output logic [PAL_W-1:0]  pal_data_o,
    output logic              textmode_o,
    output logic              monotext_o,
    output logic              linechr_mode_o,
    output logic              textblink_o,
    output logic              splitpanning_o,
    output logic              colour256_o,
    output logic              coloursel4_o,
    output logic [7:0]        overscan_clr_o,
    output logic [3:0]        plane_en_o,
    output logic [1:0]        status_sel_o,
    output logic [3:0]        horiz_pan_o,
    output logic [3:0]        coloursel_o,
    output logic              pas_o
);

    attr_state_e       state_q;
    logic              ack_q;
    logic [7:0]        rdata_q;
    logic              ff_q;
    logic              pas_q;
    logic [IDX_W-1:0]  index_q;
    logic [7:0]        mode_q;
    logic [7:0]        ovsc_q;
    logic [5:0]        plen_q;
    logic [3:0]        hpan_q;
    logic [3:0]        csel_q;
    logic              pal_write_q;
    logic [PAL_AW-1:0] pal_addr_q;
    logic [PAL_W-1:0]  pal_data_q;

    io_sel_e           sel;
    logic              accept;
    logic              pal_we;
    logic [PAL_W-1:0]  shadow_rd;
    logic [7:0]        cfg_rd;
    logic [7:0]        rdata_d;

    assign sel    = io_sel_e'(io_sel_i);
    assign accept = (state_q == StIdle) && io_req_i;
    // Palette data write: flip-flop in data phase, palette index, display not owning the palette
    assign pal_we = accept && io_we_i && (sel == SelArx) && ff_q && !index_q[4] && !pas_q;

    attr_pal_shadow #(
        .NUM_PAL (NUM_PAL),
        .PAL_W   (PAL_W)
    ) u_pal_shadow (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .we_i     (pal_we),
        .waddr_i  (index_q[PAL_AW-1:0]),
        .wdata_i  (io_data_i[PAL_W-1:0]),
        .raddr_i  (index_q[PAL_AW-1:0]),
        .rdata_o  (shadow_rd)
    );

    always_comb begin
        cfg_rd = 8'h00;
        case (index_q)
            ATTR_MODE: cfg_rd = mode_q;
            ATTR_OVSC: cfg_rd = ovsc_q;
            ATTR_PLEN: cfg_rd = {2'b00, plen_q};
            ATTR_HPAN: cfg_rd = {4'h0, hpan_q};
            ATTR_CSEL: cfg_rd = {4'h0, csel_q};
            default:   cfg_rd = 8'h00;
        endcase
    end

    always_comb begin
        rdata_d = 8'h00;
        unique case (sel)
            SelArx:  rdata_d = {2'b00, pas_q, index_q};
            SelArdr: rdata_d = index_q[4] ? cfg_rd : 8'(shadow_rd);
            SelSt01: rdata_d = {4'h0, vblank_i, 2'b00, hblank_i | vblank_i};
            SelNone: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            ack_q       <= 1'b0;
            rdata_q     <= 8'h00;
            ff_q        <= 1'b0;
            pas_q       <= 1'b0;
            index_q     <= '0;
            mode_q      <= 8'h00;
            ovsc_q      <= 8'h00;
            plen_q      <= 6'h00;
            hpan_q      <= 4'h0;
            csel_q      <= 4'h0;
            pal_write_q <= 1'b0;
            pal_addr_q  <= '0;
            pal_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                        rdata_q <= io_we_i ? 8'h00 : rdata_d;
                        if (io_we_i && (sel == SelArx)) begin
                            if (!ff_q) begin
                                index_q <= io_data_i[IDX_W-1:0];
                                pas_q   <= io_data_i[5];
                                ff_q    <= 1'b1;
                            end else begin
                                ff_q <= 1'b0;
                                if (index_q[4]) begin
                                    case (index_q)
                                        ATTR_MODE: mode_q <= io_data_i;
                                        ATTR_OVSC: ovsc_q <= io_data_i;
                                        ATTR_PLEN: plen_q <= io_data_i[5:0];
                                        ATTR_HPAN: hpan_q <= io_data_i[3:0];
                                        ATTR_CSEL: csel_q <= io_data_i[3:0];
                                        default:   ;
                                    endcase
                                end else if (!pas_q) begin
                                    pal_write_q <= 1'b1;
                                    pal_addr_q  <= index_q[PAL_AW-1:0];
                                    pal_data_q  <= io_data_i[PAL_W-1:0];
                                end
                            end
                        end
                        // Reading status resets the index/data flip-flop
                        if (!io_we_i && (sel == SelSt01)) begin
                            ff_q <= 1'b0;
                        end
                    end
                end
                StAck: begin
                    state_q     <= StIdle;
                    ack_q       <= 1'b0;
                    pal_write_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign io_ack_o       = ack_q;
    assign io_data_o      = rdata_q;
    assign pal_write_o    = pal_write_q;
    assign pal_addr_o     = pal_addr_q;
    assign pal_data_o     = pal_data_q;
    assign textmode_o     = ~mode_q[0];
    assign monotext_o     = mode_q[1];
    assign linechr_mode_o = mode_q[2];
    assign textblink_o    = mode_q[3];
    assign splitpanning_o = mode_q[5];
    assign colour256_o    = mode_q[6];
    assign coloursel4_o   = mode_q[7];
    assign overscan_clr_o = ovsc_q;
    assign plane_en_o     = plen_q[3:0];
    assign status_sel_o   = plen_q[5:4];
    assign horiz_pan_o    = hpan_q;
    assign coloursel_o    = csel_q;
    assign pas_o          = pas_q;

endmodule

// File: tb/tb_attr_regs.sv
// Self-checking bench for attr_regs: vector table with a read-data scoreboard plus corner sequences.
module tb_attr_regs;

    localparam logic [1:0] ARX  = 2'd0;
    localparam logic [1:0] ARDR = 2'd1;
    localparam logic [1:0] ST01 = 2'd2;
    localparam logic [1:0] SEL3 = 2'd3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       io_req = 1'b0;
    logic       io_we = 1'b0;
    logic [1:0] io_sel = 2'd0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;
    logic       io_ack;
    logic       hblank = 1'b0;
    logic       vblank = 1'b0;
    logic       pal_write;
    logic [3:0] pal_addr;
    logic [5:0] pal_data;
    logic       textmode, monotext, linechr_mode, textblink, splitpanning, colour256, coloursel4;
    logic [7:0] overscan_clr;
    logic [3:0] plane_en;
    logic [1:0] status_sel;
    logic [3:0] horiz_pan;
    logic [3:0] coloursel;
    logic       pas;

    attr_regs dut (
        .clock_i        (clock),
        .reset_ni       (reset_n),
        .io_req_i       (io_req),
        .io_we_i        (io_we),
        .io_sel_i       (io_sel),
        .io_data_i      (io_wdata),
        .io_data_o      (io_rdata),
        .io_ack_o       (io_ack),
        .hblank_i       (hblank),
        .vblank_i       (vblank),
        .pal_write_o    (pal_write),
        .pal_addr_o     (pal_addr),
        .pal_data_o     (pal_data),
        .textmode_o     (textmode),
        .monotext_o     (monotext),
        .linechr_mode_o (linechr_mode),
        .textblink_o    (textblink),
        .splitpanning_o (splitpanning),
        .colour256_o    (colour256),
        .coloursel4_o   (coloursel4),
        .overscan_clr_o (overscan_clr),
        .plane_en_o     (plane_en),
        .status_sel_o   (status_sel),
        .horiz_pan_o    (horiz_pan),
        .coloursel_o    (coloursel),
        .pas_o          (pas)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        logic       we;
        logic [7:0] data;
        logic       hb;
        logic       vb;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       chk;
        logic [7:0] exp;
    } sb_t;

    vec_t vecs [44];
    sb_t  sb_q [$];
    int   total = 0;
    int   bad = 0;
    int   pal_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every ack pops one entry; reads compare the returned data.
    always @(negedge clock) begin
        if (io_ack) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk) check("read_data", io_rdata, e.exp);
            end
        end
        if (pal_write) pal_cnt++;
    end

    task automatic access(input logic [1:0] sel, input logic we, input logic [7:0] data,
                          input logic hb, input logic vb, input logic [7:0] exp);
        bit got;
        int n;
        @(negedge clock);
        io_req = 1'b1;
        io_we = we;
        io_sel = sel;
        io_wdata = data;
        hblank = hb;
        vblank = vb;
        sb_q.push_back('{chk: !we, exp: exp});
        got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            @(negedge clock);
            n++;
            if (io_ack) got = 1'b1;
        end
        io_req = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack in 8 cycles, expected ack");
            sb_q.delete();
        end
    endtask

    task automatic wv(input int i, input logic [1:0] sel, input logic [7:0] data);
        vecs[i] = '{sel: sel, we: 1'b1, data: data, hb: 1'b0, vb: 1'b0, exp: 8'h00};
    endtask

    task automatic rv(input int i, input logic [1:0] sel, input logic hb, input logic vb,
                      input logic [7:0] exp);
        vecs[i] = '{sel: sel, we: 1'b0, data: 8'h00, hb: hb, vb: vb, exp: exp};
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            access(vecs[i].sel, vecs[i].we, vecs[i].data, vecs[i].hb, vecs[i].vb, vecs[i].exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, {7'b0, io_ack}, 8'h00);
        check({tag, "_pal_write"}, {7'b0, pal_write}, 8'h00);
        check({tag, "_pal_addr"}, {4'b0, pal_addr}, 8'h00);
        check({tag, "_pal_data"}, {2'b0, pal_data}, 8'h00);
        check({tag, "_mode_bits"}, {1'b0, coloursel4, colour256, splitpanning, textblink,
                                    linechr_mode, monotext, textmode}, 8'h01);
        check({tag, "_overscan"}, overscan_clr, 8'h00);
        check({tag, "_plen"}, {2'b0, status_sel, plane_en}, 8'h00);
        check({tag, "_hpan_csel"}, {horiz_pan, coloursel}, 8'h00);
        check({tag, "_pas"}, {7'b0, pas}, 8'h00);
        check({tag, "_rdata"}, io_rdata, 8'h00);
    endtask

    initial begin
        bit [5:0] ackpat;
        int       pal_before;

        rv(0, ARX, 0, 0, 8'h00);   rv(1, ARDR, 0, 0, 8'h00);  rv(2, SEL3, 0, 0, 8'h00);
        wv(3, ARX, 8'h10);         rv(4, ARDR, 0, 0, 8'h00);  rv(5, ST01, 1, 0, 8'h01);
        wv(6, ARX, 8'h05);         wv(7, ARX, 8'h2A);         rv(8, ARDR, 0, 0, 8'h2A);
        wv(9, ARX, 8'h25);         wv(10, ARX, 8'h11);        rv(11, ARDR, 0, 0, 8'h2A);
        rv(12, ARX, 0, 0, 8'h25);
        wv(13, ARX, 8'h10);        wv(14, ARX, 8'h41);        wv(15, ARX, 8'h12);
        wv(16, ARX, 8'h3F);
        rv(17, ARDR, 0, 0, 8'h3F); wv(18, ARX, 8'h10);        wv(19, ARX, 8'hD0);
        rv(20, ARDR, 0, 0, 8'hD0); wv(21, ARX, 8'h13);        rv(22, ST01, 0, 1, 8'h09);
        wv(23, ARX, 8'h14);        rv(24, ARX, 0, 0, 8'h14);  wv(25, ARX, 8'h07);
        wv(26, ARX, 8'h14);        rv(27, ARDR, 0, 0, 8'h07); wv(28, ARX, 8'h9C);
        rv(29, ARDR, 0, 0, 8'h0C); wv(30, ARX, 8'h18);        wv(31, ARX, 8'hFF);
        rv(32, ARDR, 0, 0, 8'h00); wv(33, ARX, 8'h11);        wv(34, ARX, 8'hA5);
        rv(35, ARDR, 0, 0, 8'hA5); wv(36, ARX, 8'h13);        wv(37, ARDR, 8'hFF);
        wv(38, SEL3, 8'hFF);       wv(39, ST01, 8'hFF);       wv(40, ARX, 8'h0F);
        rv(41, ARDR, 0, 0, 8'h0F); rv(42, ARX, 0, 0, 8'h13);  rv(43, ST01, 0, 0, 8'h00);

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_vecs(0, 12);
        check("pas_set", {7'b0, pas}, 8'h01);
        check("pal_strobes_a", pal_cnt[7:0], 8'h01);
        check("pal_addr", {4'b0, pal_addr}, 8'h05);
        check("pal_data", {2'b0, pal_data}, 8'h2A);

        run_vecs(13, 16);
        check("mode41", {colour256, textmode, 6'b0}, 8'h80);
        check("plen3f", {2'b0, status_sel, plane_en}, 8'h3F);
        check("pas_clr", {7'b0, pas}, 8'h00);

        run_vecs(17, 43);
        check("modeD0", {1'b0, coloursel4, colour256, splitpanning, textblink,
                         linechr_mode, monotext, textmode}, 8'h61);
        check("overscan", overscan_clr, 8'hA5);
        check("hpan_csel", {horiz_pan, coloursel}, 8'hFC);
        check("pal_strobes_b", pal_cnt[7:0], 8'h01);

        // Reset asserted while a palette write is being acknowledged
        access(ARX, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
        pal_before = pal_cnt;
        @(negedge clock);
        io_req = 1'b1;
        io_we = 1'b1;
        io_sel = ARX;
        io_wdata = 8'h2B;
        sb_q.push_back('{chk: 1'b0, exp: 8'h00});
        @(posedge clock);
        #2;
        check("pre_reset_ack", {6'b0, io_ack, pal_write}, 8'h03);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        io_req = 1'b0;
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        check("no_strobe_after_reset", pal_cnt[7:0], pal_before[7:0]);

        access(ARX, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
        access(ARDR, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

        // Request held high for six cycles: three accesses, two cycles apart
        @(negedge clock);
        io_req = 1'b1;
        io_we = 1'b0;
        io_sel = ARX;
        repeat (3) sb_q.push_back('{chk: 1'b1, exp: 8'h03});
        ackpat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ackpat[i] = io_ack;
        end
        io_req = 1'b0;
        check("held_req_ack_pattern", {2'b0, ackpat}, 8'h15);
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 8'(sb_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past 200us, expected completion");
        $fatal(1);
    end

endmodule
